keypad_scan_ctrl: RTL and testbench

Scan controller for a 4x4 matrix keypad. Drives the column lines one at a time, samples the row lines once per column dwell, and debounces a detected press by requiring consecutive identical samples. Reports a single-cycle `key_valid` with a 4-bit key code, plus a held level. Sits between the keypad pins and the display/command logic that consumes key events.

---
 rtl/keypad_pkg.sv | 34 +++
 rtl/keypad_scan_ctrl_if.sv | 19 +
 rtl/sync2.sv | 24 ++
 rtl/keypad_scan_ctrl.sv | 126 ++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
// Pure declarations; no timing or flow control of its own.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    PRESSED
  } state_t;

  localparam logic [3:0] ROWS_IDLE = 4'hF;

  typedef struct packed {
    logic       single;
    logic [1:0] idx;
  } onehot0_t;

  // Locates the low bit of an active-low row pattern; single is set only when exactly one row is low.
  function automatic onehot0_t onehot0_idx(input logic [3:0] v);
    onehot0_t r;
    int       zeros;
    r     = '0;
    zeros = 0;
    for (int i = 0; i < 4; i++) begin
      if (!v[i]) begin
        zeros = zeros + 1;
        r.idx = 2'(i);
      end
    end
    r.single = (zeros == 1);
    return r;
  endfunction

endpackage

// File: rtl/keypad_scan_ctrl_if.sv
// Keypad pin and key-event bundle between the scanner and its neighbours.
// No latency; key events are single-cycle pulses with no backpressure.
interface keypad_scan_ctrl_if;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (
    input  row,
    output col, key_code, key_valid, key_held
  );

  modport slave (
    output row,
    input  col, key_code, key_valid, key_held
  );
endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous level inputs, resetting to all ones.
// Latency 2 cycles; no flow control.
module sync2 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: one column driven low per dwell, rows debounced over DB_N dwell samples.
// key_valid follows the accepting sample tick by one cycle; events cannot be stalled by the consumer.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 1000,
  parameter int DB_N     = 4
) (
  input logic              clk,
  input logic              reset,
  keypad_scan_ctrl_if.master kp
);

  localparam int              DIV_W    = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0]       DB_LAST  = 4'(DB_N);

  logic [3:0]       row_s;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  state_t           state, state_nxt;
  logic [1:0]       col_idx, col_idx_nxt;
  logic [3:0]       pat, pat_nxt;
  logic [3:0]       cnt, cnt_nxt;
  logic [3:0]       rel_cnt, rel_cnt_nxt;
  logic [3:0]       key_code_nxt;
  logic             key_valid_nxt;
  onehot0_t         pat_dec;

  sync2 #(.WIDTH(4)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (kp.row),
    .q     (row_s)
  );

  assign tick    = (div_cnt == DIV_LAST);
  assign pat_dec = onehot0_idx(pat);

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= SCAN;
      col_idx      <= 2'd0;
      pat          <= ROWS_IDLE;
      cnt          <= 4'd0;
      rel_cnt      <= 4'd0;
      kp.key_code  <= 4'd0;
      kp.key_valid <= 1'b0;
    end else begin
      state        <= state_nxt;
      col_idx      <= col_idx_nxt;
      pat          <= pat_nxt;
      cnt          <= cnt_nxt;
      rel_cnt      <= rel_cnt_nxt;
      kp.key_code  <= key_code_nxt;
      kp.key_valid <= key_valid_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    col_idx_nxt   = col_idx;
    pat_nxt       = pat;
    cnt_nxt       = cnt;
    rel_cnt_nxt   = rel_cnt;
    key_code_nxt  = kp.key_code;
    key_valid_nxt = 1'b0;
    if (tick) begin
      case (state)
        SCAN: begin
          if (row_s == ROWS_IDLE) begin
            col_idx_nxt = col_idx + 2'd1;
          end else begin
            pat_nxt   = row_s;
            cnt_nxt   = 4'd1;
            state_nxt = DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (row_s == pat) begin
            cnt_nxt = cnt + 4'd1;
            if (cnt_nxt == DB_LAST) begin
              if (pat_dec.single) begin
                state_nxt     = PRESSED;
                key_code_nxt  = {pat_dec.idx, col_idx};
                key_valid_nxt = 1'b1;
              end else begin
                // Chorded rows are ambiguous; move on without an event.
                state_nxt   = SCAN;
                col_idx_nxt = col_idx + 2'd1;
              end
            end
          end else if (row_s == ROWS_IDLE) begin
            state_nxt = SCAN;
          end else begin
            pat_nxt = row_s;
            cnt_nxt = 4'd1;
          end
        end
        PRESSED: begin
          rel_cnt_nxt = (row_s == ROWS_IDLE) ? rel_cnt + 4'd1 : 4'd0;
          if (rel_cnt_nxt == DB_LAST) begin
            state_nxt   = SCAN;
            col_idx_nxt = col_idx + 2'd1;
            rel_cnt_nxt = 4'd0;
          end
        end
        default: state_nxt = SCAN;
      endcase
    end
  end

  assign kp.col      = ~(4'b0001 << col_idx);
  assign kp.key_held = (state == PRESSED);

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed keypad scenarios plus random key sequences, checked every cycle against a behavioural model.
module tb_keypad_scan_ctrl;

  localparam int SCAN_DIV = 4;
  localparam int DB_N     = 3;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] keys  = '0;
  logic        chk_en = 1'b0;

  int checks = 0;
  int errors = 0;

  keypad_scan_ctrl_if kif();

  keypad_scan_ctrl #(.SCAN_DIV(SCAN_DIV), .DB_N(DB_N)) dut (
    .clk   (clk),
    .reset (reset),
    .kp    (kif.master)
  );

  always #5 clk = ~clk;

  // Resistive keypad: a pressed key shorts its row to its column when that column is driven low.
  always_comb begin
    kif.row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[4*r+c] && !kif.col[c]) kif.row[r] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [3:0] col_pat(input int c);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << (c % 4));
  endfunction

  function automatic int zero_idx(input logic [3:0] v);
    int idx;
    idx = 0;
    for (int i = 0; i < 4; i++) if (!v[i]) idx = i;
    return idx;
  endfunction

  // Reference model: modes 0 scanning, 1 confirming, 2 holding.
  logic [3:0] m_q0 = 4'hF, m_q1 = 4'hF, m_pat = 4'hF;
  int m_t = 0, m_mode = 0, m_col = 0, m_run = 0, m_idle = 0, m_code = 0, m_valid = 0;

  initial begin : ref_model
    logic [3:0] rs;
    forever begin
      @(posedge clk);
      if (reset) begin
        m_q0 = 4'hF; m_q1 = 4'hF; m_pat = 4'hF;
        m_t = 0; m_mode = 0; m_col = 0; m_run = 0; m_idle = 0; m_code = 0; m_valid = 0;
      end else begin
        rs      = m_q0;
        m_q0    = m_q1;
        m_q1    = kif.row;
        m_valid = 0;
        if (m_t % SCAN_DIV == SCAN_DIV - 1) begin
          case (m_mode)
            0: begin
              if (rs == 4'hF) m_col = (m_col + 1) % 4;
              else begin m_mode = 1; m_pat = rs; m_run = 1; end
            end
            1: begin
              if (rs == m_pat) begin
                m_run++;
                if (m_run == DB_N) begin
                  if ($countones(~m_pat) == 1) begin
                    m_mode = 2; m_code = 4 * zero_idx(m_pat) + m_col; m_valid = 1; m_idle = 0;
                  end else begin
                    m_mode = 0; m_col = (m_col + 1) % 4;
                  end
                end
              end else if (rs == 4'hF) m_mode = 0;
              else begin m_pat = rs; m_run = 1; end
            end
            default: begin
              if (rs == 4'hF) m_idle++; else m_idle = 0;
              if (m_idle == DB_N) begin m_mode = 0; m_col = (m_col + 1) % 4; m_idle = 0; end
            end
          endcase
        end
        m_t++;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_col", 32'(kif.col), 32'(col_pat(m_col)));
      check("model_valid", 32'(kif.key_valid), m_valid);
      check("model_held", 32'(kif.key_held), (m_mode == 2) ? 32'd1 : 32'd0);
      check("model_code", 32'(kif.key_code), m_code);
    end
  end

  // Returns just after the last reset edge, i.e. at the start of cycle 0.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    keys  = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    do_reset();
    chk_en = 1'b1;

    // Key r1,c2 held, then released in cycle 30.
    keys = 16'h0040;
    for (int k = 0; k < 46; k++) begin
      @(negedge clk);
      check("t1_col", 32'(kif.col),
            (k < 4) ? 32'hE : (k < 8) ? 32'hD : (k < 44) ? 32'hB : 32'h7);
      check("t1_valid", 32'(kif.key_valid), (k == 20) ? 32'd1 : 32'd0);
      check("t1_held", 32'(kif.key_held), (k >= 20 && k < 44) ? 32'd1 : 32'd0);
      check("t1_code", 32'(kif.key_code), (k >= 20) ? 32'd6 : 32'd0);
      if (k == 30) keys = '0;
    end

    // Bounce on r0,c0: low one tick, high one tick, then low.
    do_reset();
    keys = 16'h0001;
    for (int k = 0; k < 31; k++) begin
      @(negedge clk);
      check("t3_valid", 32'(kif.key_valid), (k == 20) ? 32'd1 : 32'd0);
      check("t3_held", 32'(kif.key_held), (k >= 20) ? 32'd1 : 32'd0);
      if (k == 20) check("t3_code", 32'(kif.key_code), 32'd0);
      if (k == 4) keys = '0;
      if (k == 8) keys = 16'h0001;
    end

    // Two keys in column 1: rejected, scan moves to column 2.
    do_reset();
    keys = 16'h0202;
    for (int k = 0; k < 41; k++) begin
      @(negedge clk);
      check("t4_valid", 32'(kif.key_valid), 32'd0);
      check("t4_held", 32'(kif.key_held), 32'd0);
      if (k == 15) check("t4_col_hold", 32'(kif.col), 32'hD);
      if (k == 16) check("t4_col_adv", 32'(kif.col), 32'hB);
    end

    // Reset during debounce, then idle scanning.
    do_reset();
    keys = 16'h0001;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("t5_valid_pre", 32'(kif.key_valid), 32'd0);
    end
    do_reset();
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      check("t6_col", 32'(kif.col), 32'(col_pat(k / 4)));
      check("t6_valid", 32'(kif.key_valid), 32'd0);
      check("t6_held", 32'(kif.key_held), 32'd0);
      if (k == 0) check("t5_code_rst", 32'(kif.key_code), 32'd0);
    end

    // Random key activity, including chords, bounces and resets.
    for (int s = 0; s < 40; s++) begin
      int sel;
      int a;
      int b;
      sel = int'($urandom_range(0, 9));
      a   = int'($urandom_range(0, 15));
      b   = int'($urandom_range(0, 15));
      if (sel == 0) do_reset();
      else @(negedge clk);
      if (sel < 6)      keys = 16'(1) << a;
      else if (sel < 8) keys = (16'(1) << a) | (16'(1) << b);
      else              keys = '0;
      repeat (int'($urandom_range(4, 120))) @(negedge clk);
    end

    keys = '0;
    repeat (40) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
